// File: rtl/mailbox_port_arbiter_if.sv
// Shared register-port bus between fabric requesters, the arbiter and one mailbox side.
//   req_read/req_write/req_addr/req_wdata : per-requester level-held transaction request
//   req_done/req_err/req_rdata            : completion pulse, abort flag and read data back to requesters
//   mbx_read/mbx_write/mbx_addr/mbx_wdata : downstream strobes and payload
//   mbx_ready/mbx_rdata                   : downstream completion and read data
// master = arbiter view, slave = requester/mailbox environment view.
interface mailbox_port_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_read;
    logic [NUM_REQ-1:0]    req_write;
    logic [6*NUM_REQ-1:0]  req_addr;
    logic [32*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]    req_done;
    logic [NUM_REQ-1:0]    req_err;
    logic [31:0]           req_rdata;
    logic                  mbx_read;
    logic                  mbx_write;
    logic [5:0]            mbx_addr;
    logic [31:0]           mbx_wdata;
    logic                  mbx_ready;
    logic [31:0]           mbx_rdata;

    modport master (
        input  req_read, req_write, req_addr, req_wdata, mbx_ready, mbx_rdata,
        output req_done, req_err, req_rdata, mbx_read, mbx_write, mbx_addr, mbx_wdata
    );

    modport slave (
        output req_read, req_write, req_addr, req_wdata, mbx_ready, mbx_rdata,
        input  req_done, req_err, req_rdata, mbx_read, mbx_write, mbx_addr, mbx_wdata
    );
endinterface

// File: rtl/mailbox_port_arbiter.sv
// Round-robin arbiter sharing one mailbox register port between NUM_REQ requesters.
// Each granted transaction holds the downstream strobe until mbx_ready (or a TIMEOUT
// abort), then spends one strobe-low RELEASE cycle pulsing req_done/req_err.
//   clk, resetn : clock, asynchronous active-low reset
//   bus         : requester and mailbox signals (master modport)
//   busy        : high in BUSY and RELEASE
//   grant_idx   : current or last granted requester index
module mailbox_port_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   resetn,
    mailbox_port_arbiter_if.master bus,
    output logic                   busy,
    output logic [2:0]             grant_idx
);
    localparam int unsigned IDX_W = 3;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic                 op_wr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 mbx_read_q;
    logic                 mbx_write_q;
    logic [5:0]           mbx_addr_q;
    logic [31:0]          mbx_wdata_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [NUM_REQ-1:0]   err_q;
    logic [31:0]          rdata_q;

    logic [NUM_REQ-1:0]   act;
    logic [NUM_REQ-1:0]   rot;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_wr;
    logic [5:0]           pick_addr;
    logic [31:0]          pick_wdata;

    assign act = bus.req_read | bus.req_write;

    // Rotate so bit 0 is the requester just after the pointer; a doubled vector
    // makes the wrap-around free.
    assign rot = NUM_REQ'({act, act} >> (32'(ptr_q) + 32'd1));

    // First active requester at or after pointer+1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!pick_valid && rot[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'((32'(ptr_q) + 32'd1 + 32'(j)) % NUM_REQ);
            end
        end
    end

    // Payload of the picked requester; read+write together counts as a write.
    always_comb begin
        pick_wr    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_wr    = bus.req_write[i];
                pick_addr  = bus.req_addr[6*i +: 6];
                pick_wdata = bus.req_wdata[32*i +: 32];
            end
        end
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDX_W'(NUM_REQ - 1);
            op_wr_q     <= 1'b0;
            cnt_q       <= '0;
            mbx_read_q  <= 1'b0;
            mbx_write_q <= 1'b0;
            mbx_addr_q  <= '0;
            mbx_wdata_q <= '0;
            done_q      <= '0;
            err_q       <= '0;
            rdata_q     <= '0;
            busy        <= 1'b0;
            grant_idx   <= '0;
        end else begin
            done_q <= '0;
            err_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_valid) begin
                        state_q     <= S_BUSY;
                        ptr_q       <= pick_idx;
                        grant_idx   <= pick_idx;
                        op_wr_q     <= pick_wr;
                        mbx_read_q  <= ~pick_wr;
                        mbx_write_q <= pick_wr;
                        mbx_addr_q  <= pick_addr;
                        mbx_wdata_q <= pick_wdata;
                        cnt_q       <= '0;
                        busy        <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (bus.mbx_ready) begin
                        state_q     <= S_RELEASE;
                        mbx_read_q  <= 1'b0;
                        mbx_write_q <= 1'b0;
                        rdata_q     <= op_wr_q ? 32'd0 : bus.mbx_rdata;
                        done_q      <= NUM_REQ'(1) << grant_idx;
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Address never answered: abort with an error pulse.
                        state_q     <= S_RELEASE;
                        mbx_read_q  <= 1'b0;
                        mbx_write_q <= 1'b0;
                        rdata_q     <= '0;
                        done_q      <= NUM_REQ'(1) << grant_idx;
                        err_q       <= NUM_REQ'(1) << grant_idx;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    // Strobe-low turnaround lets the mailbox clear its ready.
                    state_q <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_done  = done_q;
    assign bus.req_err   = err_q;
    assign bus.req_rdata = rdata_q;
    assign bus.mbx_read  = mbx_read_q;
    assign bus.mbx_write = mbx_write_q;
    assign bus.mbx_addr  = mbx_addr_q;
    assign bus.mbx_wdata = mbx_wdata_q;
endmodule

// File: tb/tb_mailbox_port_arbiter.sv
// Testbench for mailbox_port_arbiter: requester drivers, a mailbox model with
// configurable ready latency (writes to offset 0 never answer), and a round-robin
// reference model with a shadow register map.
module tb_mailbox_port_arbiter;
    localparam int N  = 4;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       resetn;
    logic       mb_rst_n;
    logic       busy;
    logic [2:0] grant_idx;

    always #5 clk = ~clk;

    mailbox_port_arbiter_if #(.NUM_REQ(N)) bus ();

    mailbox_port_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus.master),
        .busy      (busy),
        .grant_idx (grant_idx)
    );

    // Requester drivers
    logic [N-1:0] t_rd;
    logic [N-1:0] t_wr;
    logic [5:0]   t_addr  [N];
    logic [31:0]  t_wdata [N];

    assign bus.req_read  = t_rd;
    assign bus.req_write = t_wr;
    always_comb begin
        for (int i = 0; i < N; i++) begin
            bus.req_addr[6*i +: 6]    = t_addr[i];
            bus.req_wdata[32*i +: 32] = t_wdata[i];
        end
    end

    // Mailbox model
    logic [31:0] mem [64];
    logic        mb_ready_q;
    logic [31:0] mb_rdata_q;
    int          mb_cnt;
    int          mb_lat;
    logic        inject_ready;

    function automatic logic [31:0] init_word(input int a);
        return (a == 0) ? 32'd1 : (32'h5EED_0000 ^ (32'(a) * 32'h0001_0103));
    endfunction

    assign bus.mbx_ready = mb_ready_q | inject_ready;
    assign bus.mbx_rdata = mb_rdata_q;

    always @(posedge clk or negedge mb_rst_n) begin
        if (!mb_rst_n) begin
            mb_ready_q <= 1'b0;
            mb_rdata_q <= 32'd0;
            mb_cnt     <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
        end else if ((bus.mbx_read || bus.mbx_write) && !mb_ready_q) begin
            if (mb_cnt >= mb_lat && !(bus.mbx_write && bus.mbx_addr == 6'd0)) begin
                mb_ready_q <= 1'b1;
                if (bus.mbx_write) begin
                    mem[bus.mbx_addr] <= bus.mbx_wdata;
                    mb_rdata_q        <= $urandom;
                end else begin
                    mb_rdata_q <= mem[bus.mbx_addr];
                end
            end
            mb_cnt <= mb_cnt + 1;
        end else begin
            mb_ready_q <= 1'b0;
            mb_cnt     <= 0;
        end
    end

    // Reference model state
    logic [31:0] ref_mem [64];
    int          ref_ptr;
    int          served_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int rr_next(input logic [N-1:0] mask, input int ptr);
        for (int k = 1; k <= N; k++) begin
            if (mask[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    // Complete `count` transactions from the currently pending requests,
    // checking each against the reference model.
    task automatic serve(input int count, input bit keep, output int last_cyc);
        int          exp_idx;
        int          strobes;
        int          cyc;
        int          got;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [N-1:0] exp_oh;
        last_cyc = 0;
        for (int t = 0; t < count; t++) begin
            exp_idx = rr_next(t_rd | t_wr, ref_ptr);
            if (exp_idx < 0) begin
                n_vec++; n_err++;
                $display("FAIL serve_model: no pending request left, required one");
                return;
            end
            exp_err = t_wr[exp_idx] && (t_addr[exp_idx] == 6'd0);
            exp_rd  = t_wr[exp_idx] ? 32'd0 : ref_mem[t_addr[exp_idx]];
            exp_oh  = N'(1) << exp_idx;
            strobes = 0;
            cyc     = 0;
            do begin
                @(negedge clk);
                cyc++;
                if (bus.mbx_read || bus.mbx_write) strobes++;
            end while (bus.req_done == '0 && cyc < 60);
            last_cyc = cyc;

            n_vec++;
            if (bus.req_done !== exp_oh) begin
                n_err++;
                $display("FAIL serve_done: req_done=%b required %b after %0d cycles", bus.req_done, exp_oh, cyc);
            end
            n_vec++;
            if (bus.req_err !== (exp_err ? exp_oh : '0)) begin
                n_err++;
                $display("FAIL serve_err: req_err=%b required %b", bus.req_err, exp_err ? exp_oh : '0);
            end
            n_vec++;
            if (bus.req_rdata !== exp_rd) begin
                n_err++;
                $display("FAIL serve_rdata: req_rdata=%h required %h", bus.req_rdata, exp_rd);
            end
            n_vec++;
            if (strobes != (exp_err ? TO : mb_lat + 2)) begin
                n_err++;
                $display("FAIL serve_strobe_len: strobe cycles=%0d required %0d", strobes, exp_err ? TO : mb_lat + 2);
            end
            n_vec++;
            if ((bus.mbx_read | bus.mbx_write) !== 1'b0) begin
                n_err++;
                $display("FAIL serve_turnaround: strobe=%b required 0 in done cycle", bus.mbx_read | bus.mbx_write);
            end
            n_vec++;
            if (grant_idx !== 3'(exp_idx)) begin
                n_err++;
                $display("FAIL serve_grant_idx: grant_idx=%0d required %0d", grant_idx, exp_idx);
            end

            got = -1;
            for (int i = 0; i < N; i++) if (bus.req_done[i] && got < 0) got = i;
            served_q.push_back(got);
            ref_ptr = exp_idx;
            if (t_wr[exp_idx] && !exp_err) ref_mem[t_addr[exp_idx]] = t_wdata[exp_idx];
            if (!keep) begin
                t_rd[exp_idx] = 1'b0;
                t_wr[exp_idx] = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({bus.req_done, bus.req_err, bus.mbx_read, bus.mbx_write, busy, grant_idx} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: done=%b err=%b rd=%b wr=%b busy=%b grant=%0d required all 0",
                     bus.req_done, bus.req_err, bus.mbx_read, bus.mbx_write, busy, grant_idx);
        end
        n_vec++;
        if ({bus.req_rdata, bus.mbx_addr, bus.mbx_wdata} !== '0) begin
            n_err++;
            $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0", bus.req_rdata, bus.mbx_addr, bus.mbx_wdata);
        end
    endtask

    task automatic check_order(input string name, input int exp_ord [$]);
        n_vec++;
        if (served_q.size() != exp_ord.size()) begin
            n_err++;
            $display("FAIL %s_count: served %0d required %0d", name, served_q.size(), exp_ord.size());
        end else begin
            for (int k = 0; k < exp_ord.size(); k++) begin
                n_vec++;
                if (served_q[k] != exp_ord[k]) begin
                    n_err++;
                    $display("FAIL %s_order[%0d]: idx=%0d required %0d", name, k, served_q[k], exp_ord[k]);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int c;
        int ord_a [$];
        int ord_b [$];
        ord_a = '{0, 2, 3};
        ord_b = '{0, 1, 2, 3};
        @(negedge clk);
        mb_lat = 0;
        served_q.delete();
        foreach (ord_a[k]) begin
            t_rd[ord_a[k]]    = 1'b1;
            t_addr[ord_a[k]]  = 6'($urandom_range(1, 63));
            t_wdata[ord_a[k]] = $urandom;
        end
        serve(3, 1'b0, c);
        check_order("simul", ord_a);
        served_q.delete();
        for (int i = 0; i < N; i++) begin
            t_wr[i]    = 1'b1;
            t_addr[i]  = 6'($urandom_range(1, 63));
            t_wdata[i] = $urandom;
        end
        serve(4, 1'b0, c);
        check_order("rerequest", ord_b);
    endtask

    task automatic test_basic_read();
        int c;
        @(negedge clk);
        mb_lat    = 0;
        t_rd[1]   = 1'b1;
        t_addr[1] = 6'h00;
        serve(1, 1'b0, c);
        n_vec++;
        if (c != 3) begin
            n_err++;
            $display("FAIL basic_latency: done after %0d cycles required 3", c);
        end
        n_vec++;
        if (bus.req_rdata !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL basic_rdata: req_rdata=%h required 00000001", bus.req_rdata);
        end
        @(negedge clk);
        n_vec++;
        if (bus.req_rdata !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL basic_rdata_hold: req_rdata=%h required 00000001", bus.req_rdata);
        end
    endtask

    task automatic test_timeout();
        int c;
        @(negedge clk);
        mb_lat     = 0;
        t_wr[2]    = 1'b1;
        t_addr[2]  = 6'h00;
        t_wdata[2] = $urandom;
        serve(1, 1'b0, c);
        n_vec++;
        if (bus.req_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL timeout_rdata: req_rdata=%h required 0", bus.req_rdata);
        end
        inject_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({bus.req_done, bus.req_err, busy, bus.mbx_read, bus.mbx_write} !== '0) begin
            n_err++;
            $display("FAIL timeout_late_ready: done=%b err=%b busy=%b rd=%b wr=%b required all 0",
                     bus.req_done, bus.req_err, busy, bus.mbx_read, bus.mbx_write);
        end
        inject_ready = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, bus.mbx_read, bus.mbx_write} !== 3'b000 || bus.req_rdata !== 32'd0) begin
            n_err++;
            $display("FAIL timeout_idle: busy=%b rd=%b wr=%b rdata=%h required idle with rdata 0",
                     busy, bus.mbx_read, bus.mbx_write, bus.req_rdata);
        end
    endtask

    task automatic test_read_write_both();
        int c;
        @(negedge clk);
        mb_lat     = 0;
        t_rd[0]    = 1'b1;
        t_wr[0]    = 1'b1;
        t_addr[0]  = 6'h30;
        t_wdata[0] = 32'hA5A5_0001;
        @(negedge clk);
        n_vec++;
        if (bus.mbx_write !== 1'b1 || bus.mbx_read !== 1'b0) begin
            n_err++;
            $display("FAIL rw_strobes: mbx_write=%b mbx_read=%b required 1/0", bus.mbx_write, bus.mbx_read);
        end
        n_vec++;
        if (bus.mbx_wdata !== 32'hA5A5_0001 || bus.mbx_addr !== 6'h30) begin
            n_err++;
            $display("FAIL rw_payload: wdata=%h addr=%h required a5a50001/30", bus.mbx_wdata, bus.mbx_addr);
        end
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (bus.req_done == '0 && c < 20);
        n_vec++;
        if (bus.req_done !== 4'b0001 || bus.req_err !== 4'b0000) begin
            n_err++;
            $display("FAIL rw_done: done=%b err=%b required 0001/0000", bus.req_done, bus.req_err);
        end
        t_rd[0] = 1'b0;
        t_wr[0] = 1'b0;
        ref_ptr = 0;
        ref_mem[6'h30] = 32'hA5A5_0001;
        @(negedge clk);
        t_rd[1]   = 1'b1;
        t_addr[1] = 6'h30;
        serve(1, 1'b0, c);
    endtask

    task automatic test_back_to_back();
        int c1;
        int c2;
        @(negedge clk);
        mb_lat    = 0;
        t_rd[2]   = 1'b1;
        t_addr[2] = 6'($urandom_range(0, 63));
        serve(1, 1'b1, c1);
        serve(1, 1'b0, c2);
        n_vec++;
        if (c2 != 4) begin
            n_err++;
            $display("FAIL b2b_gap: second done %0d cycles after first, required 4", c2);
        end
    endtask

    task automatic test_reset_mid();
        int c;
        int ord [$];
        ord = '{0, 3};
        @(negedge clk);
        mb_lat    = 6;
        t_rd[1]   = 1'b1;
        t_addr[1] = 6'($urandom_range(0, 63));
        @(negedge clk);
        @(negedge clk);
        t_rd[3]   = 1'b1;
        t_addr[3] = 6'($urandom_range(0, 63));
        n_vec++;
        if (bus.mbx_read !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rstmid_pre: mbx_read=%b busy=%b required 1/1", bus.mbx_read, busy);
        end
        #1 resetn = 1'b0;
        #1;
        n_vec++;
        if (bus.mbx_read !== 1'b0 || bus.mbx_write !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_strobes: rd=%b wr=%b required 0/0", bus.mbx_read, bus.mbx_write);
        end
        n_vec++;
        if (busy !== 1'b0 || bus.req_done !== '0) begin
            n_err++;
            $display("FAIL rstmid_busy_done: busy=%b done=%b required 0", busy, bus.req_done);
        end
        t_rd[1]   = 1'b0;
        t_rd[0]   = 1'b1;
        t_addr[0] = 6'($urandom_range(0, 63));
        @(posedge clk);
        #1 resetn = 1'b1;
        ref_ptr = N - 1;
        mb_lat  = 0;
        served_q.delete();
        serve(2, 1'b0, c);
        check_order("rstmid", ord);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            logic [N-1:0] mask;
            int           cnt;
            int           c;
            @(negedge clk);
            mb_lat = $urandom_range(0, 3);
            mask   = N'($urandom_range(1, (1 << N) - 1));
            cnt    = 0;
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    int op;
                    op         = $urandom_range(0, 2);
                    t_rd[i]    = (op != 1);
                    t_wr[i]    = (op != 0);
                    t_addr[i]  = ($urandom_range(0, 5) == 0) ? 6'h00 : 6'($urandom_range(1, 63));
                    t_wdata[i] = $urandom;
                    cnt++;
                end
            end
            serve(cnt, 1'b0, c);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn       = 1'b0;
        mb_rst_n     = 1'b0;
        inject_ready = 1'b0;
        mb_lat       = 0;
        t_rd         = '0;
        t_wr         = '0;
        for (int i = 0; i < N; i++) begin
            t_addr[i]  = '0;
            t_wdata[i] = '0;
        end
        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        ref_ptr = N - 1;
        repeat (2) @(posedge clk);
        #1;
        resetn   = 1'b1;
        mb_rst_n = 1'b1;

        test_reset();
        test_simultaneous();
        test_basic_read();
        test_timeout();
        test_read_write_both();
        test_back_to_back();
        test_reset_mid();
        test_random();

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mailbox_port_arbiter.md
# mailbox_port_arbiter

Round-robin arbiter that shares one side (A or B) of the mailbox controller's register port between up to NUM_REQ fabric requesters, such as a hart bridge, a DMA descriptor engine or a debug master. Each transaction is issued as a level-held read or write. The arbiter holds the downstream strobe until the mailbox returns ready, then drops it for a mandatory turnaround cycle. A timeout aborts transactions to addresses that never return ready, such as writes to read-only offsets.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT, 255, maximum BUSY cycles waiting for mbx_ready before abort (1..65535)

- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- req_read  in  NUM_REQ  per-requester read request, level
- req_write  in  NUM_REQ  per-requester write request, level
- req_addr  in  6*NUM_REQ  packed byte addresses; requester i uses bits [6i+5:6i]
- req_wdata  in  32*NUM_REQ  packed write data; requester i uses bits [32i+31:32i]
- req_done  out  NUM_REQ  one-cycle completion pulse to the granted requester
- req_err  out  NUM_REQ  one-cycle pulse, coincident with req_done, on timeout abort
- req_rdata  out  32  read data, valid only while req_done is high
- mbx_read  out  1  downstream read strobe
- mbx_write  out  1  downstream write strobe
- mbx_addr  out  6  downstream address
- mbx_wdata  out  32  downstream write data
- mbx_ready  in  1  downstream completion (registered in the mailbox)
- mbx_rdata  in  32  downstream read data
- busy  out  1  high in BUSY and RELEASE
- grant_idx  out  3  index of the current or last granted requester

## Operation
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - The round-robin pointer is NUM_REQ-1, so requester 0 wins first.
- A requester is active if req_read[i] or req_write[i] is high.
  - If both are high, the request is treated as a write.
- Requester contract:
  - Hold req_*, addr and wdata stable until req_done.
  - Deassert on the same edge req_done is sampled.
  - A request still high in the following IDLE cycle is a new transaction.
- FSM states:
  - IDLE:
    - If no request is active, remain in IDLE.
    - Otherwise grant the first active index searching upward from pointer+1, modulo NUM_REQ.
    - Latch index, op, addr and wdata.
    - Set the pointer to the granted index, clear the timeout counter and go to BUSY.
  - BUSY:
    - mbx_read or mbx_write is high per the latched op; mbx_addr and mbx_wdata come from the latches.
    - If mbx_ready is high: capture mbx_rdata into req_rdata (0 for writes) and go to RELEASE.
    - Else, if the counter equals TIMEOUT-1: req_rdata <= 0, flag the error and go to RELEASE.
    - Else increment the counter.
  - RELEASE:
    - Both strobes are low.
    - req_done[idx] is high, and req_err[idx] is high if the transaction was aborted.
    - Go to IDLE unconditionally. This guarantees the mailbox sees a strobe-low cycle and clears its ready.
- mbx_ready is ignored in IDLE and RELEASE, including a late ready after an abort.
- Request inputs change nothing once the request is latched; a requester dropping its request in BUSY does not cancel the transaction.
- Counter width is clog2(TIMEOUT+1).
- grant_idx width is fixed at 3; unused upper bits are 0.
- Asserting resetn mid-transaction immediately drops the strobes, done and err, and returns the FSM to IDLE with the pointer at NUM_REQ-1.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Request sampled in IDLE at edge n: strobe high in cycle n+1.
- Mailbox ready high no earlier than cycle n+2.
- req_done high in the cycle after ready is sampled, i.e. cycle n+3 at the earliest.
- Back to IDLE at cycle n+4.
- Minimum transaction time is 4 cycles; maximum back-to-back throughput is 1 transaction per 4 cycles.
- Timeout abort: strobe high for exactly TIMEOUT cycles, then req_done and req_err in the next cycle.
- req_rdata holds its value after req_done until the next RELEASE.

## Test plan
- Basic read:
  - Stimulus: requester 1 reads 0x00 with the mailbox returning version 1.
  - Required: mbx_read high for exactly 2 cycles, req_done[1] pulses 3 cycles after the request edge, req_rdata = 0x00000001, req_err = 0.
- Simultaneous requests:
  - Stimulus: requesters 0, 2 and 3 request simultaneously, each holding its request until done.
  - Required: service order 0, 2, 3, with a strobe-low cycle between each transaction.
  - Follow-up: re-request all four immediately after pointer = 3.
  - Required: order 0, 1, 2, 3.
- Timeout abort:
  - Stimulus: with TIMEOUT = 8, requester 2 writes 0x00, for which the mailbox gives no ready.
  - Required: mbx_write high for exactly 8 cycles, then req_done[2] = req_err[2] = 1 and req_rdata = 0.
  - Required: a ready injected during RELEASE is ignored.
- Read and write both asserted:
  - Stimulus: requester 0 asserts req_read and req_write together at addr 0x30 with wdata 0xA5A5_0001.
  - Required: mbx_write = 1, mbx_read = 0, mbx_wdata = 0xA5A5_0001.
- Reset mid-transaction:
  - Stimulus: pulse resetn low for half a cycle while in BUSY.
  - Required: mbx_read, mbx_write, busy and req_done go low asynchronously.
  - Required: after release, requester 0 wins over a pending requester 3.
- Re-request without deassert:
  - Stimulus: a sole requester keeps its request high after done.
  - Required: a second transaction starts exactly 1 IDLE cycle after RELEASE.
